// File: rtl/mm_pkg.sv
// Shared constants and types for the modular-multiplier sharing scheduler.
//   Q             : Kyber/NTT modulus used by the shared Barrett multiplier
//   DataWidthDef  : default operand/result width
//   MulLatDef     : default multiplier latency (edges from operand to product)
//   NumReqDef     : default requester count
//   BurstMaxDef   : default consecutive-grant limit
//   req_id_t      : requester id for the default requester count
package mm_pkg;

    localparam int unsigned Q            = 3329;
    localparam int unsigned DataWidthDef = 12;
    localparam int unsigned MulLatDef    = 4;
    localparam int unsigned NumReqDef    = 4;
    localparam int unsigned BurstMaxDef  = 8;
    localparam int unsigned ReqIdW       = $clog2(NumReqDef);

    typedef logic [ReqIdW-1:0] req_id_t;

endpackage

// File: rtl/mm_tag_line.sv
// Delay line of {valid, id} tags that tracks products through the multiplier.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all tags)
//   in_valid_i    : an operation is issued this cycle
//   in_id_i       : id of the issuing requester
//   out_valid_o   : last stage holds a valid tag
//   out_id_o      : id held in the last stage
//   any_valid_o   : at least one stage holds a valid tag
module mm_tag_line #(
    parameter int unsigned Depth = 4,
    parameter int unsigned IdW   = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    input  logic [IdW-1:0] in_id_i,
    output logic           out_valid_o,
    output logic [IdW-1:0] out_id_o,
    output logic           any_valid_o
);

    logic [Depth-1:0] valid_q;
    logic [IdW-1:0]   id_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int s = 0; s < Depth; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            id_q[0]    <= in_id_i;
            for (int s = 1; s < Depth; s++) begin
                valid_q[s] <= valid_q[s-1];
                id_q[s]    <= id_q[s-1];
            end
        end
    end

    assign out_valid_o = valid_q[Depth-1];
    assign out_id_o    = id_q[Depth-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/mm_share_sched.sv
// Round-robin scheduler sharing one pipelined modular multiplier among requesters.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   hold_i          : suppress new grants; in-flight products still return
//   req_valid_i     : per-requester operand valid
//   req_ready_o     : one-hot combinational grant
//   req_a_i/req_b_i : packed operands, requester i at [i*DataWidth +: DataWidth]
//   mul_a_o/mul_b_o : operand bus to the multiplier (0 when idle)
//   mul_p_i         : product from the multiplier, MulLat edges after the operands
//   rsp_valid_o     : registered one-hot result strobe
//   rsp_data_o      : registered shared result bus
//   busy_o          : operation in flight or grant given
module mm_share_sched
    import mm_pkg::*;
#(
    parameter int unsigned DataWidth = DataWidthDef,
    parameter int unsigned NumReq    = NumReqDef,
    parameter int unsigned MulLat    = MulLatDef,
    parameter int unsigned BurstMax  = BurstMaxDef
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        hold_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*DataWidth-1:0] req_a_i,
    input  logic [NumReq*DataWidth-1:0] req_b_i,
    output logic [DataWidth-1:0]        mul_a_o,
    output logic [DataWidth-1:0]        mul_b_o,
    input  logic [DataWidth-1:0]        mul_p_i,
    output logic [NumReq-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]        rsp_data_o,
    output logic                        busy_o
);

    localparam int unsigned IdW = $clog2(NumReq);
    localparam int unsigned BcW = $clog2(BurstMax + 1);

    logic [IdW-1:0]       owner_q, owner_d;
    logic                 owner_vld_q, owner_vld_d;
    logic [BcW-1:0]       burst_q, burst_d;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NumReq-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;

    logic           keep;
    logic           found;
    logic [IdW-1:0] gnt_idx;
    logic [IdW:0]   scan;
    logic           tail_vld;
    logic [IdW-1:0] tail_id;
    logic           any_vld;

    // Grant: owner keeps it below the burst limit, otherwise first valid from rr_ptr.
    always_comb begin
        keep    = 1'b0;
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (rst_ni && !hold_i) begin
            keep = owner_vld_q && req_valid_i[owner_q] && (burst_q < BcW'(BurstMax));
            if (keep) begin
                found   = 1'b1;
                gnt_idx = owner_q;
            end else begin
                // Walk backwards so the lowest scan offset is assigned last and wins.
                for (int k = NumReq - 1; k >= 0; k--) begin
                    scan = {1'b0, rr_ptr_q} + (IdW+1)'(k);
                    if (scan >= (IdW+1)'(NumReq)) begin
                        scan = scan - (IdW+1)'(NumReq);
                    end
                    if (req_valid_i[scan[IdW-1:0]]) begin
                        found   = 1'b1;
                        gnt_idx = scan[IdW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        mul_a_o     = '0;
        mul_b_o     = '0;
        if (found) begin
            req_ready_o[gnt_idx] = 1'b1;
            mul_a_o = req_a_i[gnt_idx*DataWidth +: DataWidth];
            mul_b_o = req_b_i[gnt_idx*DataWidth +: DataWidth];
        end
    end

    // Arbiter state; hold freezes owner, burst count and pointer.
    always_comb begin
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_d     = burst_q;
        rr_ptr_d    = rr_ptr_q;
        if (!hold_i) begin
            if (found) begin
                owner_d     = gnt_idx;
                owner_vld_d = 1'b1;
                // A re-grant to the same requester at the limit restarts at 1.
                burst_d     = keep ? burst_q + BcW'(1) : BcW'(1);
                rr_ptr_d    = (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + IdW'(1);
            end else begin
                owner_vld_d = 1'b0;
                burst_d     = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_q     <= burst_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    mm_tag_line #(
        .Depth (MulLat),
        .IdW   (IdW)
    ) u_tag_line (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (found),
        .in_id_i     (gnt_idx),
        .out_valid_o (tail_vld),
        .out_id_o    (tail_id),
        .any_valid_o (any_vld)
    );

    // Product is on mul_p_i while its tag sits in the last stage.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tail_vld) begin
            rsp_valid_d = NumReq'(1) << tail_id;
            rsp_data_d  = mul_p_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = any_vld | found;

endmodule

// File: tb/tb_mm_share_sched.sv
// Bench for mm_share_sched: behavioural arbiter/scoreboard model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mm_share_sched;
    import mm_pkg::*;

    localparam int N     = 4;
    localparam int W     = 12;
    localparam int Lat   = 4;
    localparam int Burst = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [W-1:0]   mul_p;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mm_share_sched #(
        .DataWidth (W),
        .NumReq    (N),
        .MulLat    (Lat),
        .BurstMax  (Burst)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .hold_i      (hold),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_p_i     (mul_p),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
    );

    // Multiplier stand-in: exact modular product, Lat edges from operands to mul_p.
    logic [W-1:0] p_pipe [Lat];
    initial for (int s = 0; s < Lat; s++) p_pipe[s] = '0;
    always @(posedge clk) begin
        p_pipe[0] <= W'((int'(mul_a) * int'(mul_b)) % Q);
        for (int s = 1; s < Lat; s++) p_pipe[s] <= p_pipe[s-1];
    end
    assign mul_p = p_pipe[Lat-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int id;
        int data;
    } rsp_t;

    rsp_t sb[$];
    int   cyc = 0;
    int   own = 0;
    bit   own_v = 0;
    int   cnt = 0;
    int   last_own = -1;
    int   last_data = 0;
    int   g;
    int   ea, eb;
    int   exp_rv;
    bit   exp_busy;

    function automatic int model_grant();
        int start;
        if (hold) return -1;
        if (own_v && req_valid[own] && cnt < Burst) return own;
        start = (last_own < 0) ? 0 : (last_own + 1) % N;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            own_v = 0; own = 0; cnt = 0; last_own = -1; last_data = 0;
            sb.delete();
            check("rst_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_busy", busy, 0);
        end else begin
            g  = model_grant();
            ea = (g < 0) ? 0 : int'(req_a[g*W +: W]);
            eb = (g < 0) ? 0 : int'(req_b[g*W +: W]);
            check("ready", req_ready, (g < 0) ? 0 : (1 << g));
            check("mul_a", mul_a, ea);
            check("mul_b", mul_b, eb);
            exp_rv = 0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_rv    = 1 << sb[0].id;
                last_data = sb[0].data;
                void'(sb.pop_front());
            end
            check("rsp_valid", rsp_valid, exp_rv);
            check("rsp_data", rsp_data, last_data);
            exp_busy = (sb.size() > 0) || (g >= 0);
            check("busy", busy, exp_busy);
            if (g >= 0) sb.push_back('{cyc + Lat + 1, g, (ea * eb) % Q});
            if (!hold) begin
                if (g < 0) begin
                    own_v = 0; cnt = 0;
                end else begin
                    if (own_v && g == own && cnt < Burst) cnt++;
                    else cnt = 1;
                    own = g; own_v = 1; last_own = g;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        step();
        step();
        rst_n = 1'b1;

        // Single issue from r0: 100*200 mod 3329 = 26, rsp five cycles later.
        req_valid = 4'b0001;
        req_a[0 +: W] = 12'd100;
        req_b[0 +: W] = 12'd200;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        check("t1_mul_a", mul_a, 100);
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_busy", busy, 1);
            step();
        end
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 4'b0001);
        check("t1_rsp_data", rsp_data, 26);
        check("t1_busy_idle", busy, 0);
        drain(2);

        // Back-to-back products from r2.
        req_valid = 4'b0100;
        req_a[2*W +: W] = 12'd3328; req_b[2*W +: W] = 12'd3328; step();
        req_a[2*W +: W] = 12'd2;    req_b[2*W +: W] = 12'd1665; step();
        req_a[2*W +: W] = 12'd1234; req_b[2*W +: W] = 12'd0;    step();
        req_valid = '0;
        step();
        step();
        @(negedge clk);
        check("t3_rv0", rsp_valid, 4'b0100); check("t3_d0", rsp_data, 1);
        step();
        @(negedge clk);
        check("t3_rv1", rsp_valid, 4'b0100); check("t3_d1", rsp_data, 1);
        step();
        @(negedge clk);
        check("t3_rv2", rsp_valid, 4'b0100); check("t3_d2", rsp_data, 0);
        drain(3);

        // All four valid: 8 grants each, rotating r0..r3.
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = W'((c * 37 + i * 501) % 3329);
                req_b[i*W +: W] = W'((c * 11 + i * 7 + 3) % 3329);
            end
            @(negedge clk);
            check("t2_grant", req_ready, 1 << ((c / 8) % 4));
            step();
        end
        drain(7);

        // Hold mid-burst: r1 owns with count 3, then 5 more grants before rotating to r3.
        do_reset();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check("t4_pre", req_ready, 4'b0010); step();
        end
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check("t4_hold", req_ready, 4'b0000); step();
        end
        hold = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); check("t4_post", req_ready, 4'b0010); step();
        end
        @(negedge clk);
        check("t4_rotate", req_ready, 4'b1000);
        step();
        drain(7);

        // Reset mid-operation drops in-flight tags; first grant goes to lowest valid.
        req_valid = 4'b1000;
        repeat (3) step();
        rst_n = 1'b0;
        req_valid = 4'b1110;
        #1;
        check("t5_async_busy", busy, 0);
        check("t5_async_ready", req_ready, 0);
        check("t5_async_rsp", rsp_valid, 0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_first", req_ready, 4'b0010);
        step();
        drain(8);

        // Only r3 valid beyond the burst limit: granted every cycle.
        req_valid = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            req_a[3*W +: W] = W'(c * 131 + 5);
            req_b[3*W +: W] = W'(c * 17 + 900);
            @(negedge clk);
            check("t6_grant", req_ready, 4'b1000);
            step();
        end
        drain(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mm_share_sched.md
Name: mm_share_sched

Overview:
- Round-robin scheduler that shares one Barrett modular multiplier (q = 3329, 12-bit operands, fixed 4-cycle latency) among NUM_REQ requesters, e.g. butterfly units and twiddle-update logic in the NTT core.
- Arbitrates operand issue with a burst limit and drives the multiplier operand bus.
- Tracks each issued product through a tag delay line matching the multiplier latency.
- Returns each result with a one-hot valid to the requester that issued it.

Parameters:
- data_width, 12, operand/result width
- NUM_REQ, 4, number of requesters (2..8)
- MUL_LAT, 4, multiplier latency in clock edges from operand to product
- BURST_MAX, 8, max consecutive grants to one requester before forced rotation

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- hold  in  1  1 = issue no new operations; in-flight ones still complete
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  one-hot grant, combinational; transfer when req_valid[i] & req_ready[i]
- req_a  in  NUM_REQ*data_width  packed operand A, requester i at [i*data_width +: data_width]
- req_b  in  NUM_REQ*data_width  packed operand B, same packing
- mul_a  out  data_width  operand A to the multiplier
- mul_b  out  data_width  operand B to the multiplier
- mul_p  in  data_width  product from the multiplier
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered
- rsp_data  out  data_width  result, shared bus, registered
- busy  out  1  1 while any operation is in flight or any grant is given

Behaviour:
- Reset (rst=0, async): rr pointer=0, burst count=0, current owner=none, tag line cleared, rsp_valid=0, rsp_data=0, busy=0. req_ready=0 while in reset.
- Arbitration is combinational from the registered state.
  - If hold=1, req_ready=0.
  - Otherwise, if the current owner still has req_valid=1 and burst count < BURST_MAX, the owner keeps the grant.
  - Otherwise the grant goes to the first req_valid=1 requester scanning from (last owner+1) mod NUM_REQ.
  - If no requester is valid, there is no grant.
- State update on a grant:
  - Owner changes: owner <= i, burst count <= 1.
  - Owner unchanged: burst count <= burst count + 1.
  - No grant: owner <= none, burst count <= 0.
  - BURST_MAX reached while other requesters are valid: rotate to the next valid requester.
  - BURST_MAX reached with no other requester valid: same requester is re-granted and the count restarts at 1.
- Operand bus: mul_a/mul_b = granted req_a/req_b. They are forced to 0 when there is no grant, so an idle multiplier yields product 0.
- Throughput: one issue per cycle, no bubbles between requesters.
- Tag line: MUL_LAT-deep shift register of {valid, id}, id width $clog2(NUM_REQ), shifted every cycle.
  - Stage 0 loads {1, i} on an issue and {0, x} otherwise.
  - When the last stage is valid with id k, then at the next edge: rsp_valid <= one-hot(k), rsp_data <= mul_p.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Total issue-to-rsp_valid latency = MUL_LAT+1 cycles.
- Responses have no backpressure. Each requester must accept rsp_valid in the cycle it is asserted.
- hold affects new grants only. Asserting hold mid-burst freezes the owner and the burst count. When hold is released, the same owner continues if it is still valid.
- busy = any tag stage valid | any req_ready bit set.
- Reset mid-operation drops all in-flight tags: no rsp_valid for them after reset is released.
- Results return in issue order. Requesters are not reordered relative to each other.

Decomposition:
- Shared package mm_pkg holds:
  - Q = 3329 and data_width default 12
  - MUL_LAT = 4
  - the requester-id typedef (width $clog2(NUM_REQ))
- One natural sub-module, mm_tag_line: the parameterised {valid,id} delay line with async active-low reset.
- The round-robin and burst logic stays in mm_share_sched.

Test Plan:
- Single requester 0 issues A=100, B=200 at cycle t -> rsp_valid=4'b0001 at t+5, rsp_data=26; busy high t..t+4.
- Requesters 0..3 all valid continuously, BURST_MAX=8 -> grants 8x r0, then 8x r1, r2, r3, r0. No idle issue cycles. Each rsp_valid id matches the issue order 5 cycles earlier.
- Back-to-back products from requester 2: (3328,3328), then (2,1665), then (1234,0) -> rsp_data 1, 1, 0 on consecutive cycles, rsp_valid=4'b0100 each.
- hold=1 for 3 cycles mid-burst with r1 owning, count=3 -> req_ready=0 during hold, tags in flight still return. After release r1 continues and rotates after 5 more grants.
- rst pulsed low 2 cycles after 3 issues -> no rsp_valid for those issues. All outputs 0 immediately (async). The first post-reset grant goes to the lowest valid index.
- Only r3 valid, BURST_MAX exceeded -> r3 re-granted every cycle without a gap; burst count wraps to 1.
